// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline latches: FSM state encoding and the
// packed EX/MEM payload that callers pack into / unpack from the opaque data bus.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } elastic_state_t;

  localparam int EXMEM_W = 145;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [1:0]  mem_to_reg;
    logic [4:0]  wsel;
    logic [5:0]  opcode;
    logic [31:0] word3;
    logic [31:0] word2;
    logic [31:0] word1;
    logic [31:0] word0;
  } exmem_payload_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running 32-bit event counter; wraps modulo 2^32 rather than saturating.
module pipe_perf_cnt (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= 32'd0;
    end else if (inc) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline latch (main + skid) with registered in_ready and sync flush.
// Define PIPE_STAGE_PERF_EN to add stall_cnt / flush_cnt performance counters.
//
// state | meaning
// EMPTY | nothing held, out_valid=0
// ONE   | head payload in main
// FULL  | head in main, next payload in skid, in_ready=0
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH        = EXMEM_W,
  parameter bit CLR_ON_FLUSH = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  elastic_state_t   state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, pop;
  logic             load_main_in, load_main_skid, load_skid;

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = (state == FULL) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
    end
  end

  // in_ready is precomputed from the next state so it never sees out_ready combinationally
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
      if (flush) begin
        if (CLR_ON_FLUSH) begin
          main_q <= '0;
          skid_q <= '0;
        end
      end else begin
        if (load_main_in) begin
          main_q <= in_data;
        end else if (load_main_skid) begin
          main_q <= skid_q;
        end
        if (load_skid) begin
          skid_q <= in_data;
        end
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  pipe_perf_cnt u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush & (state != EMPTY)),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_elastic;

  localparam int W = 145;

  logic         CLK;
  logic         nRST;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  flush_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  pipe_stage_elastic #(.WIDTH(W), .CLR_ON_FLUSH(1'b1)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a FIFO of capacity two, cleared by reset or flush.
  logic [W-1:0] mq[$];
  bit           zero_known = 1'b1;
  bit           m_acc, m_pop;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mq.delete();
      zero_known = 1'b1;
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      m_pop = out_ready && (mq.size() > 0);
      if (flush) begin
        mq.delete();
        zero_known = 1'b1;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_acc) begin
          mq.push_back(in_data);
          zero_known = 1'b0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("m_occupancy", W'(occupancy), W'(mq.size()));
    chk("m_in_ready",  W'(in_ready),  W'(mq.size() < 2));
    chk("m_out_valid", W'(out_valid), W'(mq.size() > 0));
    if (mq.size() > 0)   chk("m_out_data", out_data, mq[0]);
    else if (zero_known) chk("m_out_data_zero", out_data, '0);
  end

  // Drive one cycle of inputs; returns just after the following falling edge.
  task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12 nRST = 1'b1;
    @(negedge CLK); #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready",  W'(in_ready),  W'(1));
    chk("rst_occupancy", W'(occupancy), '0);
    chk("rst_out_data",  out_data,      '0);

    // streaming, one per cycle, one-cycle lag
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, W'(i), 1'b1, 1'b0);
      chk("stream_data",  out_data,     W'(i));
      chk("stream_ready", W'(in_ready), W'(1));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drained", W'(out_valid), '0);

    // backpressure then ordered release
    cyc(1'b1, W'('hA), 1'b0, 1'b0);
    cyc(1'b1, W'('hB), 1'b0, 1'b0);
    chk("bp_occ",   W'(occupancy), W'(2));
    chk("bp_ready", W'(in_ready),  '0);
    cyc(1'b1, W'('hC), 1'b0, 1'b0);
    chk("bp_hold_occ",  W'(occupancy), W'(2));
    chk("bp_hold_data", out_data,      W'('hA));
    cyc(1'b1, W'('hC), 1'b1, 1'b0);
    chk("bp_rel_b", out_data, W'('hB));
    cyc(1'b1, W'('hC), 1'b1, 1'b0);
    chk("bp_rel_c", out_data, W'('hC));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("bp_empty", W'(occupancy), '0);

    // flush while FULL with a simultaneous offered word
    cyc(1'b1, W'('h11), 1'b0, 1'b0);
    cyc(1'b1, W'('h12), 1'b0, 1'b0);
    cyc(1'b1, W'('hD), 1'b0, 1'b1);
    chk("flush_occ",   W'(occupancy), '0);
    chk("flush_valid", W'(out_valid), '0);
    chk("flush_data",  out_data,      '0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("flush_no_d", W'(out_valid), '0);

    // accept and pop together in ONE
    cyc(1'b1, W'('h21), 1'b0, 1'b0);
    cyc(1'b1, W'('h22), 1'b1, 1'b0);
    chk("swap_occ",  W'(occupancy), W'(1));
    chk("swap_data", out_data,      W'('h22));
    cyc(1'b0, '0, 1'b1, 1'b1);

    // asynchronous reset mid-transfer
    cyc(1'b1, W'('h41), 1'b0, 1'b0);
    cyc(1'b1, W'('h42), 1'b0, 1'b0);
    in_valid = 1'b1; in_data = W'('h43); out_ready = 1'b1;
    #2 nRST = 1'b0;
    #1;
    chk("arst_out_valid", W'(out_valid), '0);
    chk("arst_in_ready",  W'(in_ready),  W'(1));
    chk("arst_occupancy", W'(occupancy), '0);
    chk("arst_out_data",  out_data,      '0);
    @(negedge CLK); #1;
    nRST = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("arst_after", W'(out_valid), '0);

`ifdef PIPE_STAGE_PERF_EN
    nRST = 1'b0; #2 nRST = 1'b1;
    chk("perf_rst_stall", W'(stall_cnt), '0);
    chk("perf_rst_flush", W'(flush_cnt), '0);
    cyc(1'b1, W'('h31), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b1, W'('h33), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("perf_stall", W'(stall_cnt), W'(5));
    chk("perf_flush", W'(flush_cnt), W'(2));
`endif

    cyc(1'b0, '0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
